// File: rtl/seq_nr_divider_pkg.sv
// seq_nr_divider_pkg: shared state encoding and sizing helper for the divider
package seq_nr_divider_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_ZERO = 2'd3
  } div_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_nr_divider_add_sub_n.sv
// add_sub_n: N-bit ripple adder/subtractor, mode=1 computes a-b
module add_sub_n #(
  parameter int N = 5
) (
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] bx;
  logic         cy;

  assign bx = b ^ {N{mode}};

  // carry ripples bit by bit; subtraction injects carry-in through mode
  always_comb begin
    cy  = mode;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ bx[i] ^ cy;
      cy     = (a[i] & bx[i]) | (cy & (a[i] ^ bx[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/seq_nr_divider.sv
// seq_nr_divider: multi-cycle unsigned non-restoring divider, one quotient bit per clock
module seq_nr_divider
  import seq_nr_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept, run, fix, zero, last;
  logic             as_mode, unused_cout;
  logic [WIDTH:0]   as_a, as_b, as_sum;

  assign accept = (state_q == DIV_IDLE) && start;
  assign run    = state_q == DIV_RUN;
  assign fix    = state_q == DIV_FIX;
  assign zero   = state_q == DIV_ZERO;
  assign last   = cnt_q == LAST;

  // RUN adds/subtracts D from the shifted P by P's sign; FIX only ever adds D back
  assign as_a    = run ? {p_q[WIDTH-1:0], q_q[WIDTH-1]} : p_q;
  assign as_b    = {1'b0, d_q};
  assign as_mode = run & ~p_q[WIDTH];

  add_sub_n #(.N(WIDTH + 1)) u_add_sub (
    .mode (as_mode),
    .a    (as_a),
    .b    (as_b),
    .sum  (as_sum),
    .cout (unused_cout)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DIV_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q == DIV_IDLE ? (start ? (divisor == '0 ? DIV_ZERO : DIV_RUN) : DIV_IDLE) :
              state_q == DIV_RUN  ? (last ? DIV_FIX : DIV_RUN) :
                                    DIV_IDLE;
  end

  // datapath and result next-state
  always_comb begin
    p_d    = accept ? '0 : run ? as_sum : p_q;
    q_d    = accept ? dividend : run ? {q_q[WIDTH-2:0], ~as_sum[WIDTH]} : q_q;
    d_d    = accept ? divisor : d_q;
    cnt_d  = run ? (last ? '0 : cnt_q + 1'b1) : accept ? '0 : cnt_q;
    busy_d = accept ? 1'b1 : (fix | zero) ? 1'b0 : busy_q;
    done_d = fix | zero;
    quot_d = fix ? q_q : zero ? '1 : quot_q;
    rem_d  = fix ? (p_q[WIDTH] ? as_sum[WIDTH-1:0] : p_q[WIDTH-1:0]) : zero ? q_q : rem_q;
    dbz_d  = accept ? 1'b0 : zero ? 1'b1 : dbz_q;
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      p_q    <= p_d;
      q_q    <= q_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_nr_divider.sv
// tb_seq_nr_divider: randomized and directed checks of the divider against an arithmetic model
module tb_seq_nr_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;
  int held_q = 0;
  int held_r = 0;

  seq_nr_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_op(input int a, input int b);
    int n, lat, eq, er;
    lat = b == 0 ? 1 : W + 1;
    eq  = b == 0 ? (1 << W) - 1 : a / b;
    er  = b == 0 ? a : a % b;
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 3 * W) begin
      check("busy_run", busy, 1);
      check("held_q", quotient, held_q);
      check("held_r", remainder, held_r);
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, lat);
    check("quot", quotient, eq);
    check("rem", remainder, er);
    check("dbz", div_by_zero, b == 0);
    check("busy_done", busy, 0);
    held_q = eq;
    held_r = er;
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("dbz_hold", div_by_zero, b == 0);
    check("quot_hold", quotient, eq);
  endtask

  initial begin
    int nd, last, pd;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(13, 3);
    do_op(15, 15);
    do_op(3, 7);
    do_op(0, 5);
    do_op(15, 1);
    do_op(7, 0);
    do_op(8, 2);

    for (int a = 0; a < (1 << W); a++)
      for (int b = 1; b < (1 << W); b++)
        do_op(a, b);

    repeat (40) do_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));

    @(negedge clk);
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd1;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        check("ign_quot", quotient, 4);
        check("ign_rem", remainder, 1);
      end
    end
    check("ign_ndone", nd, 1);
    held_q = 4;
    held_r = 1;

    @(negedge clk);
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quot", quotient, 0);
    check("abort_rem", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_hold_done", done, 0);
      check("abort_hold_busy", busy, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    held_q = 0;
    held_r = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      check("abort_nodone", done, 0);
    end
    do_op(14, 3);

    @(negedge clk);
    dividend = 4'd11;
    divisor  = 4'd4;
    start    = 1'b1;
    last = -1;
    nd   = 0;
    pd   = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      check("b2b_merge", done & pd[0], 0);
      if (done) begin
        nd++;
        check("b2b_quot", quotient, 2);
        check("b2b_rem", remainder, 3);
        if (last >= 0) check("b2b_gap", c - last, W + 2);
        last = c;
      end
      pd = int'(done);
    end
    check("b2b_count", nd, 6);
    start = 1'b0;
    for (int c = 0; c < 20 && busy; c++) begin
      @(posedge clk);
      #1;
    end
    check("b2b_drain", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
